// File: rtl/xtal_freq_meter.sv
// Crystal frequency meter. Counts synchronized rising edges of xtal_in over
// a fixed window of GATE_CYCLES clk cycles. The count, an overflow flag and an
// in-range flag are presented with a valid/ready handshake.
module xtal_freq_meter #(
    parameter int unsigned GATE_CYCLES  = 4_800_000,
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned MIN_CNT      = 1_188_000,
    parameter int unsigned MAX_CNT      = 1_212_000,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter bit          AUTO_RESTART = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             xtal_in,
    input  logic             start,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_count,
    output logic             overflow,
    output logic             in_range,
    output logic             busy
);
    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [GATE_W-1:0] GATE_INIT = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 prev_q;
    logic                 rise;
    logic [WARM_W-1:0]    warm_cnt_q;
    logic                 warm_done;
    logic [GATE_W-1:0]    gate_cnt_q;
    logic [CNT_W-1:0]     edge_cnt_q;
    logic                 ovf_q;
    logic                 gate_start;
    logic                 gate_end;
    logic                 edge_sat;
    logic [CNT_W-1:0]     edge_nxt;
    logic                 ovf_nxt;
    logic                 range_nxt;

    // Synchronizer chain and previous-value flop for rising-edge detection.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], xtal_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Warm-up counter: blocks start until the sync chain has flushed its reset value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            warm_cnt_q <= '0;
        end else if (!warm_done) begin
            warm_cnt_q <= warm_cnt_q + WARM_W'(1);
        end
    end

    assign warm_done = (warm_cnt_q == WARM_DONE);

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; gate_start reloads the window, gate_end latches the result.
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_d    = state_q;
        gate_start = 1'b0;
        gate_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && warm_done) begin
                    state_d    = S_GATE;
                    gate_start = 1'b1;
                end
            end
            S_GATE: begin
                if (gate_cnt_q == '0) begin
                    state_d  = S_DONE;
                    gate_end = 1'b1;
                end
            end
            S_DONE: begin
                if (meas_ready) begin
                    if (AUTO_RESTART) begin
                        state_d    = S_GATE;
                        gate_start = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Saturating edge count including this cycle's rise, and the flags derived from it.
    assign edge_sat  = (edge_cnt_q == CNT_MAX);
    assign edge_nxt  = (rise && !edge_sat) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign ovf_nxt   = ovf_q | (rise & edge_sat);
    assign range_nxt = !ovf_nxt && (edge_nxt >= MIN_C) && (edge_nxt <= MAX_C);

    // Gate timer and edge accumulator; only advance while the window is open.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else if (gate_start) begin
            gate_cnt_q <= GATE_INIT;
            edge_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else if (state_q == S_GATE) begin
            if (gate_cnt_q != '0) begin
                gate_cnt_q <= gate_cnt_q - GATE_W'(1);
            end
            edge_cnt_q <= edge_nxt;
            ovf_q      <= ovf_nxt;
        end
    end

    // Result registers: loaded once at the end of a complete window, held otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meas_count <= '0;
            overflow   <= 1'b0;
            in_range   <= 1'b0;
        end else if (gate_end) begin
            meas_count <= edge_nxt;
            overflow   <= ovf_nxt;
            in_range   <= range_nxt;
        end
    end

    assign meas_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);

endmodule
